regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth is 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write ports; write port index 1 has priority over index 0.
REQ-005 The block SHALL have one clock, clk, and a synchronous, active-high reset, clk_reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 clk_reset  input  1  synchronous, active-high reset.
REQ-008 rd_en  input  NUM_RD  per-port read strobe.
REQ-009 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port p uses slice p.
REQ-010 rd_data  output  NUM_RD*DATA_W  registered read data.
REQ-011 rd_busy  output  NUM_RD  registered scoreboard bit for the register addressed at the rd_en cycle.
REQ-012 wr_en  input  NUM_WR  per-port write strobe.
REQ-013 wr_addr  input  NUM_WR*ADDR_W  write addresses.
REQ-014 wr_data  input  NUM_WR*DATA_W  write data.
REQ-015 sb_set  input  1  mark register sb_addr busy (pending writeback).
REQ-016 sb_addr  input  ADDR_W  scoreboard set address.

Function
REQ-017 Address 0 SHALL read as 0, SHALL ignore writes, and SHALL never be busy.
REQ-018 Reads SHALL have 1-cycle latency: rd_data/rd_busy update on the edge after rd_en=1 and hold while rd_en=0.
REQ-019 Writes SHALL update storage on the rising edge where wr_en=1.
REQ-020 If two write ports hit the same nonzero address in one cycle, the highest-index port SHALL win.
REQ-021 A write to register r SHALL clear busy[r] on the same edge.
REQ-022 sb_set=1 SHALL set busy[sb_addr] on the edge; if a write to the same address occurs in that cycle, set SHALL win (busy=1).
REQ-023 rd_busy SHALL reflect the busy state after that edge's set/clear, including same-cycle set/clear.
REQ-024 Storage contents are never X: every entry is defined from reset onward.

Reset
REQ-025 On clk_reset=1 at a rising edge, all registers, all busy bits, rd_data and rd_busy SHALL become 0.
REQ-026 Reset SHALL override any simultaneous write, read or sb_set in that cycle.
REQ-027 Asserting clk_reset mid-sequence SHALL discard pending busy state; the first post-reset read returns 0.

Configuration
REQ-028 Macro REGFILE_MP_BYPASS_EN, when defined, SHALL forward same-cycle write data to a matching read (priority per REQ-020), so rd_data returns the new value.
REQ-029 Without REGFILE_MP_BYPASS_EN, a same-cycle read SHALL return the pre-write (old) value.

Structure
REQ-030 Package regfile_mp_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and the zero-register index constant.
REQ-031 Sub-module regfile_mp_scoreboard SHALL implement the busy-bit vector (set/clear/read); storage and read muxing stay in regfile_mp.

Verification
REQ-032 Reset, then read addr 7 on both ports -> rd_data=0, rd_busy=0 one cycle later.
REQ-033 Write port0 addr 3 = 0xDEADBEEF; next cycle read addr 3 -> 0xDEADBEEF; write addr 0 = 0x1 then read 0 -> 0.
REQ-034 Same cycle: port0 writes addr 5 = 0x11, port1 writes addr 5 = 0x22 -> subsequent read of addr 5 = 0x22.
REQ-035 Same cycle write addr 9 = 0x55 and read addr 9 (previous 0) -> rd_data=0x55 with REGFILE_MP_BYPASS_EN, 0x0 without.
REQ-036 sb_set addr 4 -> read 4 gives rd_busy=1; write addr 4 -> next read gives rd_busy=0; sb_set addr 4 plus write addr 4 same cycle -> rd_busy=1.
REQ-037 Write addr 12 = 0xA5A5, sb_set 12, assert clk_reset one cycle -> read 12 gives rd_data=0, rd_busy=0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared default sizes and the hard-wired zero register index for regfile_mp.
package regfile_mp_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_DEF = 2;
    localparam int NUM_WR_DEF = 2;
    localparam int unsigned ZERO_REG = 0;
endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Pending-writeback busy bits: writes clear, sb_set sets (set wins), register 0 never busy.
// rd_busy is registered and reports the state after this edge's set/clear.
module regfile_mp_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     clk_reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) busy_nxt[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (sb_set) busy_nxt[sb_addr] = 1'b1;
        busy_nxt[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            busy    <= '0;
            rd_busy <= '0;
        end else begin
            busy <= busy_nxt;
            // Reads see the post-edge state so a same-cycle set/clear is visible.
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) rd_busy[p] <= busy_nxt[rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard; 1-cycle registered reads, register 0 reads as zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching reads (highest write port wins).
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int NUM_WR = NUM_WR_DEF
) (
    input  logic                     clk,
    input  logic                     clk_reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_nxt;

    // Ascending port order makes the highest-index write win on an address clash.
    always_ff @(posedge clk) begin
        if (clk_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != ZERO_ADDR)
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_nxt[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && rd_addr[p*ADDR_W +: ADDR_W] != ZERO_ADDR &&
                    wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
                    rd_nxt[p*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (clk_reset) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) rd_data[p*DATA_W +: DATA_W] <= rd_nxt[p*DATA_W +: DATA_W];
            end
        end
    end

    regfile_mp_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk       (clk),
        .clk_reset (clk_reset),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .sb_set    (sb_set),
        .sb_addr   (sb_addr)
    );
endmodule
